// File: rtl/mem_access_unit_if.sv
// Bundle of the memory-stage request port and the word-oriented data bus seen
// by mem_access_unit. The 'slave' modport is the unit's view; 'master' is the
// view of whoever drives requests and models the bus.
interface mem_access_unit_if;
    // Pipeline request / completion
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned_fault;

    // Data bus
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        input  bus_ready, bus_rvalid, bus_rdata,
        output req_ready, done, rdata, misaligned_fault,
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        output bus_ready, bus_rvalid, bus_rdata,
        input  req_ready, done, rdata, misaligned_fault,
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer. Accepts one load or store at a time,
// turns it into one or two word-aligned bus beats (two when the access spans
// a word boundary), and returns loads assembled and sign/zero-extended
// according to the datapath's truncation size code.
module mem_access_unit #(
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_access_unit_if.slave mau
);

    // Truncation size codes; 2, 5, 6 and 7 all mean a full word.
    localparam logic [2:0] SZ_BYTE   = 3'd0;
    localparam logic [2:0] SZ_HALF   = 3'd1;
    localparam logic [2:0] SZ_BYTE_U = 3'd3;
    localparam logic [2:0] SZ_HALF_U = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_RSP0,
        ST_REQ1,
        ST_RSP1,
        ST_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_done_set;

    // Latched request
    logic        r_write;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic        r_cross;

    // Registered bus fields plus the precomputed second-beat payload
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_strb_hi;
    logic [31:0] r_wdata_hi;

    // Load assembly and results
    logic [31:0] r_asm;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_fault;

    // Decode of the incoming request
    logic [2:0]  w_req_n;
    logic [3:0]  w_req_mask;
    logic [1:0]  w_req_off;
    logic        w_req_cross;
    logic [7:0]  w_req_strb8;
    logic [63:0] w_req_wdata64;

    // Control / datapath helpers
    logic        w_accept;
    logic        w_req_ready;
    logic        w_bus_valid;
    logic        w_enter_req1;
    logic        w_load_done;
    logic [4:0]  w_hi_shamt;
    logic [31:0] w_rsp0_data;
    logic [31:0] w_rsp1_data;
    logic [31:0] w_load_word;

    // Load extension from the assembled little-endian word.
    function automatic logic [31:0] f_extend(input logic [31:0] word,
                                             input logic [2:0]  size);
        logic [31:0] result;
        case (size)
            SZ_BYTE:   result = {{24{word[7]}}, word[7:0]};
            SZ_BYTE_U: result = {24'h0, word[7:0]};
            SZ_HALF:   result = {{16{word[15]}}, word[15:0]};
            SZ_HALF_U: result = {16'h0, word[15:0]};
            default:   result = word;
        endcase
        return result;
    endfunction

    // Byte count and lane mask of the incoming request.
    always_comb begin
        case (mau.req_size)
            SZ_BYTE, SZ_BYTE_U: begin
                w_req_n    = 3'd1;
                w_req_mask = 4'b0001;
            end
            SZ_HALF, SZ_HALF_U: begin
                w_req_n    = 3'd2;
                w_req_mask = 4'b0011;
            end
            default: begin
                w_req_n    = 3'd4;
                w_req_mask = 4'b1111;
            end
        endcase
    end

    // Offset within the word decides crossing; shifting into a double-width
    // field yields beat 0 in the low half and beat 1 in the high half.
    assign w_req_off     = mau.req_addr[1:0];
    assign w_req_cross   = ({1'b0, w_req_off} + w_req_n) > 3'd4;
    assign w_req_strb8   = {4'b0000, w_req_mask} << w_req_off;
    assign w_req_wdata64 = {32'h0, mau.req_wdata} << {w_req_off, 3'b000};

    assign w_accept = mau.req_valid && w_req_ready;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic and completion decision.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the case leaves it unassigned (no latch).
        w_state_next = r_state;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mau.req_valid) begin
                    if (w_req_cross && !MISALIGNED_EN) w_state_next = ST_FAULT;
                    else                               w_state_next = ST_REQ0;
                end
            end
            ST_REQ0: begin
                if (mau.bus_ready) begin
                    if (!r_write)     w_state_next = ST_RSP0;
                    else if (r_cross) w_state_next = ST_REQ1;
                    else begin
                        w_state_next = ST_IDLE;
                        w_done_set   = 1'b1;
                    end
                end
            end
            ST_RSP0: begin
                if (mau.bus_rvalid) begin
                    if (r_cross) w_state_next = ST_REQ1;
                    else begin
                        w_state_next = ST_IDLE;
                        w_done_set   = 1'b1;
                    end
                end
            end
            ST_REQ1: begin
                if (mau.bus_ready) begin
                    if (r_write) begin
                        w_state_next = ST_IDLE;
                        w_done_set   = 1'b1;
                    end else begin
                        w_state_next = ST_RSP1;
                    end
                end
            end
            ST_RSP1: begin
                if (mau.bus_rvalid) begin
                    w_state_next = ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            ST_FAULT: begin
                w_state_next = ST_IDLE;
                w_done_set   = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs; bus_valid follows the state register directly so
    // an asynchronous reset withdraws it immediately.
    always_comb begin
        w_req_ready = (r_state == ST_IDLE);
        w_bus_valid = (r_state == ST_REQ0) || (r_state == ST_REQ1);
    end

    assign w_enter_req1 = (w_state_next == ST_REQ1) && (r_state != ST_REQ1);

    // Latch the request attributes at acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_cross <= 1'b0;
        end else if (w_accept) begin
            r_write <= mau.req_write;
            r_size  <= mau.req_size;
            r_off   <= w_req_off;
            r_cross <= w_req_cross;
        end
    end

    // Bus beat fields: beat 0 loaded at acceptance, beat 1 swapped in on the
    // way into REQ1; held untouched while a beat waits for bus_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wstrb <= 4'h0;
            r_bus_wdata <= 32'h0;
            r_strb_hi   <= 4'h0;
            r_wdata_hi  <= 32'h0;
        end else if (w_accept) begin
            r_bus_we    <= mau.req_write;
            r_bus_addr  <= {mau.req_addr[31:2], 2'b00};
            r_bus_wstrb <= mau.req_write ? w_req_strb8[3:0] : 4'h0;
            r_bus_wdata <= w_req_wdata64[31:0];
            r_strb_hi   <= mau.req_write ? w_req_strb8[7:4] : 4'h0;
            r_wdata_hi  <= w_req_wdata64[63:32];
        end else if (w_enter_req1) begin
            r_bus_addr  <= r_bus_addr + 32'd4;
            r_bus_wstrb <= r_strb_hi;
            r_bus_wdata <= r_wdata_hi;
        end
    end

    // Beat 0 supplies the low result bytes; beat 1 fills bytes 4-o and up,
    // which are still zero in the assembly register after the right shift.
    assign w_rsp0_data = mau.bus_rdata >> {r_off, 3'b000};
    assign w_hi_shamt  = 5'd0 - {r_off, 3'b000};
    assign w_rsp1_data = r_asm | (mau.bus_rdata << w_hi_shamt);
    assign w_load_word = (r_state == ST_RSP1) ? w_rsp1_data : w_rsp0_data;
    assign w_load_done = mau.bus_rvalid &&
                         ((r_state == ST_RSP1) || ((r_state == ST_RSP0) && !r_cross));

    // Load assembly and extended result; rdata holds between loads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_asm   <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            if ((r_state == ST_RSP0) && mau.bus_rvalid) r_asm <= w_rsp0_data;
            if (w_load_done) r_rdata <= f_extend(w_load_word, r_size);
        end
    end

    // Registered completion and fault pulses, high in the first IDLE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_done  <= w_done_set;
            r_fault <= (r_state == ST_FAULT);
        end
    end

    assign mau.req_ready        = w_req_ready;
    assign mau.bus_valid        = w_bus_valid;
    assign mau.bus_we           = r_bus_we;
    assign mau.bus_addr         = r_bus_addr;
    assign mau.bus_wstrb        = r_bus_wstrb;
    assign mau.bus_wdata        = r_bus_wdata;
    assign mau.done             = r_done;
    assign mau.misaligned_fault = r_fault;
    assign mau.rdata            = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance with split accesses
// enabled, one with crossing accesses rejected.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_access_unit_if mif();
    mem_access_unit_if nif();

    mem_access_unit #(.MISALIGNED_EN(1'b1)) dut    (.clk(clk), .reset_n(reset_n), .mau(mif));
    mem_access_unit #(.MISALIGNED_EN(1'b0)) dut_nf (.clk(clk), .reset_n(reset_n), .mau(nif));

    int n_vec  = 0;
    int n_miss = 0;

    // Observations of the last transaction run through do_txn
    int          b_cnt;
    logic [31:0] b_addr  [0:1];
    logic [3:0]  b_strb  [0:1];
    logic [31:0] b_wdata [0:1];
    logic        b_we    [0:1];
    int          done_cyc;
    logic [31:0] res_rdata;
    logic        res_fault;

    // Runs one request on mif from an idle unit, acting as the bus: bus_ready
    // low for the first 'stall' cycles after acceptance, read data returned
    // the cycle after each read beat. Cycle 0 is the accept cycle.
    task automatic do_txn(input string name, input logic wr, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd0, input logic [31:0] rd1,
                          input int stall);
        logic pend;
        int   rd_idx;
        pend     = 1'b0;
        rd_idx   = 0;
        b_cnt    = 0;
        done_cyc = -1;
        @(negedge clk);
        mif.req_valid = 1'b1;
        mif.req_write = wr;
        mif.req_size  = sz;
        mif.req_addr  = addr;
        mif.req_wdata = wd;
        @(negedge clk);
        // Request is gone and scrambled; the unit must use its latched copy.
        mif.req_valid = 1'b0;
        mif.req_write = ~wr;
        mif.req_size  = ~sz;
        mif.req_addr  = ~addr;
        mif.req_wdata = ~wd;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            mif.bus_ready  = (c > stall);
            mif.bus_rvalid = pend;
            mif.bus_rdata  = pend ? ((rd_idx == 0) ? rd0 : rd1) : 32'h5EED_F00D;
            if (pend) rd_idx++;
            pend = 1'b0;
            if (mif.bus_valid && mif.bus_ready) begin
                if (b_cnt < 2) begin
                    b_addr[b_cnt]  = mif.bus_addr;
                    b_strb[b_cnt]  = mif.bus_wstrb;
                    b_wdata[b_cnt] = mif.bus_wdata;
                    b_we[b_cnt]    = mif.bus_we;
                end
                b_cnt++;
                if (!wr) pend = 1'b1;
            end
            if (mif.done) begin
                done_cyc  = c;
                res_rdata = mif.rdata;
                res_fault = mif.misaligned_fault;
                break;
            end
        end
        mif.bus_rvalid = 1'b0;
        mif.bus_ready  = 1'b1;
        if (done_cyc < 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s timeout: got no done in 30 cycles, expected done", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mif.req_valid = 1'b0; mif.req_write = 1'b0; mif.req_size = 3'd0;
        mif.req_addr = 32'h0; mif.req_wdata = 32'h0;
        mif.bus_ready = 1'b1; mif.bus_rvalid = 1'b0; mif.bus_rdata = 32'h0;
        nif.req_valid = 1'b0; nif.req_write = 1'b0; nif.req_size = 3'd0;
        nif.req_addr = 32'h0; nif.req_wdata = 32'h0;
        nif.bus_ready = 1'b1; nif.bus_rvalid = 1'b0; nif.bus_rdata = 32'h0;
        #1;
        n_vec++; if (mif.req_ready !== 1'b1) begin n_miss++; $display("FAIL rst req_ready: got %b, expected 1", mif.req_ready); end
        n_vec++; if (mif.bus_valid !== 1'b0) begin n_miss++; $display("FAIL rst bus_valid: got %b, expected 0", mif.bus_valid); end
        n_vec++; if (mif.bus_we !== 1'b0) begin n_miss++; $display("FAIL rst bus_we: got %b, expected 0", mif.bus_we); end
        n_vec++; if (mif.done !== 1'b0) begin n_miss++; $display("FAIL rst done: got %b, expected 0", mif.done); end
        n_vec++; if (mif.misaligned_fault !== 1'b0) begin n_miss++; $display("FAIL rst fault: got %b, expected 0", mif.misaligned_fault); end
        n_vec++; if (mif.bus_addr !== 32'h0) begin n_miss++; $display("FAIL rst bus_addr: got %h, expected 0", mif.bus_addr); end
        n_vec++; if (mif.bus_wstrb !== 4'h0) begin n_miss++; $display("FAIL rst bus_wstrb: got %h, expected 0", mif.bus_wstrb); end
        n_vec++; if (mif.bus_wdata !== 32'h0) begin n_miss++; $display("FAIL rst bus_wdata: got %h, expected 0", mif.bus_wdata); end
        n_vec++; if (mif.rdata !== 32'h0) begin n_miss++; $display("FAIL rst rdata: got %h, expected 0", mif.rdata); end
        n_vec++; if (nif.req_ready !== 1'b1) begin n_miss++; $display("FAIL rst nf req_ready: got %b, expected 1", nif.req_ready); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (mif.req_ready !== 1'b1) begin n_miss++; $display("FAIL post-rst req_ready: got %b, expected 1", mif.req_ready); end
        n_vec++; if (mif.done !== 1'b0) begin n_miss++; $display("FAIL post-rst done: got %b, expected 0", mif.done); end
    endtask

    task automatic test_byte_store();
        do_txn("byte_store", 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 32'h0, 0);
        n_vec++; if (done_cyc !== 2) begin n_miss++; $display("FAIL byte_store latency: got %0d, expected 2", done_cyc); end
        n_vec++; if (b_cnt !== 1) begin n_miss++; $display("FAIL byte_store beats: got %0d, expected 1", b_cnt); end
        n_vec++; if (b_addr[0] !== 32'h0000_1000) begin n_miss++; $display("FAIL byte_store addr: got %h, expected 00001000", b_addr[0]); end
        n_vec++; if (b_strb[0] !== 4'b1000) begin n_miss++; $display("FAIL byte_store wstrb: got %b, expected 1000", b_strb[0]); end
        n_vec++; if (b_wdata[0] !== 32'hAB00_0000) begin n_miss++; $display("FAIL byte_store wdata: got %h, expected ab000000", b_wdata[0]); end
        n_vec++; if (b_we[0] !== 1'b1) begin n_miss++; $display("FAIL byte_store we: got %b, expected 1", b_we[0]); end
        n_vec++; if (res_fault !== 1'b0) begin n_miss++; $display("FAIL byte_store fault: got %b, expected 0", res_fault); end
        // Aligned unsigned half store, upper half of the word
        do_txn("half_store", 1'b1, 3'd4, 32'h0000_5002, 32'h0000_CAFE, 32'h0, 32'h0, 0);
        n_vec++; if (b_strb[0] !== 4'b1100) begin n_miss++; $display("FAIL half_store wstrb: got %b, expected 1100", b_strb[0]); end
        n_vec++; if (b_wdata[0] !== 32'hCAFE_0000) begin n_miss++; $display("FAIL half_store wdata: got %h, expected cafe0000", b_wdata[0]); end
        // Same store with two cycles of bus_ready low: latency grows by two
        do_txn("stall_store", 1'b1, 3'd4, 32'h0000_5002, 32'h0000_CAFE, 32'h0, 32'h0, 2);
        n_vec++; if (done_cyc !== 4) begin n_miss++; $display("FAIL stall_store latency: got %0d, expected 4", done_cyc); end
    endtask

    task automatic test_loads();
        do_txn("half_load_s", 1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h80FF_1234, 32'h0, 0);
        n_vec++; if (done_cyc !== 3) begin n_miss++; $display("FAIL half_load_s latency: got %0d, expected 3", done_cyc); end
        n_vec++; if (res_rdata !== 32'hFFFF_80FF) begin n_miss++; $display("FAIL half_load_s rdata: got %h, expected ffff80ff", res_rdata); end
        n_vec++; if (b_addr[0] !== 32'h0000_2000) begin n_miss++; $display("FAIL half_load_s addr: got %h, expected 00002000", b_addr[0]); end
        n_vec++; if (b_strb[0] !== 4'h0) begin n_miss++; $display("FAIL half_load_s wstrb: got %b, expected 0000", b_strb[0]); end
        n_vec++; if (b_we[0] !== 1'b0) begin n_miss++; $display("FAIL half_load_s we: got %b, expected 0", b_we[0]); end
        do_txn("half_load_u", 1'b0, 3'd4, 32'h0000_2002, 32'h0, 32'h80FF_1234, 32'h0, 0);
        n_vec++; if (res_rdata !== 32'h0000_80FF) begin n_miss++; $display("FAIL half_load_u rdata: got %h, expected 000080ff", res_rdata); end
        do_txn("byte_load_s", 1'b0, 3'd0, 32'h0000_1001, 32'h0, 32'h0000_9A00, 32'h0, 0);
        n_vec++; if (res_rdata !== 32'hFFFF_FF9A) begin n_miss++; $display("FAIL byte_load_s rdata: got %h, expected ffffff9a", res_rdata); end
        do_txn("byte_load_u", 1'b0, 3'd3, 32'h0000_1001, 32'h0, 32'h0000_9A00, 32'h0, 0);
        n_vec++; if (res_rdata !== 32'h0000_009A) begin n_miss++; $display("FAIL byte_load_u rdata: got %h, expected 0000009a", res_rdata); end
        // Size code 7 behaves as a full word
        do_txn("size7_load", 1'b0, 3'd7, 32'h0000_7000, 32'h0, 32'h8000_0001, 32'h0, 0);
        n_vec++; if (res_rdata !== 32'h8000_0001) begin n_miss++; $display("FAIL size7_load rdata: got %h, expected 80000001", res_rdata); end
    endtask

    task automatic test_cross_store();
        do_txn("cross_store", 1'b1, 3'd2, 32'h0000_3003, 32'h1122_3344, 32'h0, 32'h0, 0);
        n_vec++; if (done_cyc !== 3) begin n_miss++; $display("FAIL cross_store latency: got %0d, expected 3", done_cyc); end
        n_vec++; if (b_cnt !== 2) begin n_miss++; $display("FAIL cross_store beats: got %0d, expected 2", b_cnt); end
        n_vec++; if (b_addr[0] !== 32'h0000_3000) begin n_miss++; $display("FAIL cross_store addr0: got %h, expected 00003000", b_addr[0]); end
        n_vec++; if (b_strb[0] !== 4'b1000) begin n_miss++; $display("FAIL cross_store wstrb0: got %b, expected 1000", b_strb[0]); end
        n_vec++; if (b_wdata[0] !== 32'h4400_0000) begin n_miss++; $display("FAIL cross_store wdata0: got %h, expected 44000000", b_wdata[0]); end
        n_vec++; if (b_addr[1] !== 32'h0000_3004) begin n_miss++; $display("FAIL cross_store addr1: got %h, expected 00003004", b_addr[1]); end
        n_vec++; if (b_strb[1] !== 4'b0111) begin n_miss++; $display("FAIL cross_store wstrb1: got %b, expected 0111", b_strb[1]); end
        n_vec++; if (b_wdata[1] !== 32'h0011_2233) begin n_miss++; $display("FAIL cross_store wdata1: got %h, expected 00112233", b_wdata[1]); end
        n_vec++; if (b_we[1] !== 1'b1) begin n_miss++; $display("FAIL cross_store we1: got %b, expected 1", b_we[1]); end
        // A store leaves the previous load result in place
        n_vec++; if (res_rdata !== 32'h8000_0001) begin n_miss++; $display("FAIL cross_store rdata hold: got %h, expected 80000001", res_rdata); end
        do_txn("cross_half_store", 1'b1, 3'd1, 32'h0000_5003, 32'h0000_BEEF, 32'h0, 32'h0, 0);
        n_vec++; if (b_strb[0] !== 4'b1000) begin n_miss++; $display("FAIL cross_half_store wstrb0: got %b, expected 1000", b_strb[0]); end
        n_vec++; if (b_wdata[0] !== 32'hEF00_0000) begin n_miss++; $display("FAIL cross_half_store wdata0: got %h, expected ef000000", b_wdata[0]); end
        n_vec++; if (b_strb[1] !== 4'b0001) begin n_miss++; $display("FAIL cross_half_store wstrb1: got %b, expected 0001", b_strb[1]); end
        n_vec++; if (b_wdata[1] !== 32'h0000_00BE) begin n_miss++; $display("FAIL cross_half_store wdata1: got %h, expected 000000be", b_wdata[1]); end
    endtask

    task automatic test_cross_load_wrap();
        do_txn("wrap_load", 1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 32'hAABB_0000, 32'h0000_CCDD, 0);
        n_vec++; if (done_cyc !== 5) begin n_miss++; $display("FAIL wrap_load latency: got %0d, expected 5", done_cyc); end
        n_vec++; if (b_addr[0] !== 32'hFFFF_FFFC) begin n_miss++; $display("FAIL wrap_load addr0: got %h, expected fffffffc", b_addr[0]); end
        n_vec++; if (b_addr[1] !== 32'h0000_0000) begin n_miss++; $display("FAIL wrap_load addr1: got %h, expected 00000000", b_addr[1]); end
        n_vec++; if (b_strb[1] !== 4'h0) begin n_miss++; $display("FAIL wrap_load wstrb1: got %b, expected 0000", b_strb[1]); end
        n_vec++; if (res_rdata !== 32'hCCDD_AABB) begin n_miss++; $display("FAIL wrap_load rdata: got %h, expected ccddaabb", res_rdata); end
        do_txn("cross_half_load", 1'b0, 3'd1, 32'h0000_6003, 32'h0, 32'h8000_0000, 32'h0000_00FF, 0);
        n_vec++; if (b_addr[1] !== 32'h0000_6004) begin n_miss++; $display("FAIL cross_half_load addr1: got %h, expected 00006004", b_addr[1]); end
        n_vec++; if (res_rdata !== 32'hFFFF_FF80) begin n_miss++; $display("FAIL cross_half_load rdata: got %h, expected ffffff80", res_rdata); end
    endtask

    task automatic test_backpressure_reset();
        @(negedge clk);
        mif.bus_ready = 1'b0;
        mif.req_valid = 1'b1; mif.req_write = 1'b1; mif.req_size = 3'd2;
        mif.req_addr = 32'h0000_8004; mif.req_wdata = 32'h1234_5678;
        @(negedge clk);
        mif.req_valid = 1'b0; mif.req_addr = 32'hFFFF_0000; mif.req_wdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            n_vec++; if (mif.bus_valid !== 1'b1) begin n_miss++; $display("FAIL stall%0d bus_valid: got %b, expected 1", c, mif.bus_valid); end
            n_vec++; if (mif.req_ready !== 1'b0) begin n_miss++; $display("FAIL stall%0d req_ready: got %b, expected 0", c, mif.req_ready); end
            n_vec++; if (mif.bus_addr !== 32'h0000_8004) begin n_miss++; $display("FAIL stall%0d addr: got %h, expected 00008004", c, mif.bus_addr); end
            n_vec++; if (mif.bus_wstrb !== 4'hF) begin n_miss++; $display("FAIL stall%0d wstrb: got %b, expected 1111", c, mif.bus_wstrb); end
            n_vec++; if (mif.bus_wdata !== 32'h1234_5678) begin n_miss++; $display("FAIL stall%0d wdata: got %h, expected 12345678", c, mif.bus_wdata); end
            n_vec++; if (mif.bus_we !== 1'b1) begin n_miss++; $display("FAIL stall%0d we: got %b, expected 1", c, mif.bus_we); end
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (mif.bus_valid !== 1'b0) begin n_miss++; $display("FAIL async_rst bus_valid: got %b, expected 0", mif.bus_valid); end
        n_vec++; if (mif.req_ready !== 1'b1) begin n_miss++; $display("FAIL async_rst req_ready: got %b, expected 1", mif.req_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        mif.bus_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++; if (mif.done !== 1'b0) begin n_miss++; $display("FAIL post_abort%0d done: got %b, expected 0", c, mif.done); end
            n_vec++; if (mif.bus_valid !== 1'b0) begin n_miss++; $display("FAIL post_abort%0d bus_valid: got %b, expected 0", c, mif.bus_valid); end
        end
    endtask

    task automatic test_fault_back_to_back();
        @(negedge clk);
        nif.req_valid = 1'b1; nif.req_write = 1'b0; nif.req_size = 3'd2;
        nif.req_addr = 32'h0000_0001; nif.req_wdata = 32'h0;
        @(negedge clk);
        // cycle 1: FAULT, nothing on the bus; queue the next request now
        n_vec++; if (nif.bus_valid !== 1'b0) begin n_miss++; $display("FAIL fault c1 bus_valid: got %b, expected 0", nif.bus_valid); end
        n_vec++; if (nif.req_ready !== 1'b0) begin n_miss++; $display("FAIL fault c1 req_ready: got %b, expected 0", nif.req_ready); end
        nif.req_valid = 1'b1; nif.req_write = 1'b1; nif.req_size = 3'd2;
        nif.req_addr = 32'h0000_0040; nif.req_wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        // cycle 2: done + fault, and the queued request is accepted
        n_vec++; if (nif.done !== 1'b1) begin n_miss++; $display("FAIL fault c2 done: got %b, expected 1", nif.done); end
        n_vec++; if (nif.misaligned_fault !== 1'b1) begin n_miss++; $display("FAIL fault c2 fault: got %b, expected 1", nif.misaligned_fault); end
        n_vec++; if (nif.bus_valid !== 1'b0) begin n_miss++; $display("FAIL fault c2 bus_valid: got %b, expected 0", nif.bus_valid); end
        n_vec++; if (nif.req_ready !== 1'b1) begin n_miss++; $display("FAIL fault c2 req_ready: got %b, expected 1", nif.req_ready); end
        n_vec++; if (nif.rdata !== 32'h0) begin n_miss++; $display("FAIL fault c2 rdata: got %h, expected 00000000", nif.rdata); end
        @(negedge clk);
        nif.req_valid = 1'b0;
        n_vec++; if (nif.bus_valid !== 1'b1) begin n_miss++; $display("FAIL b2b c3 bus_valid: got %b, expected 1", nif.bus_valid); end
        n_vec++; if (nif.bus_addr !== 32'h0000_0040) begin n_miss++; $display("FAIL b2b c3 addr: got %h, expected 00000040", nif.bus_addr); end
        n_vec++; if (nif.bus_wstrb !== 4'hF) begin n_miss++; $display("FAIL b2b c3 wstrb: got %b, expected 1111", nif.bus_wstrb); end
        n_vec++; if (nif.done !== 1'b0) begin n_miss++; $display("FAIL b2b c3 done: got %b, expected 0", nif.done); end
        @(negedge clk);
        n_vec++; if (nif.done !== 1'b1) begin n_miss++; $display("FAIL b2b c4 done: got %b, expected 1", nif.done); end
        n_vec++; if (nif.misaligned_fault !== 1'b0) begin n_miss++; $display("FAIL b2b c4 fault: got %b, expected 0", nif.misaligned_fault); end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_loads();
        test_cross_store();
        test_cross_load_wrap();
        test_backpressure_reset();
        test_fault_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store sequencer between the pipeline's memory stage and the word-oriented data bus. It takes one load or store per request, using the truncation size encoding the datapath already carries (BYTE=0, HALF_WORD=1, WORD=2, BYTE_UNSIGNED=3, HALF_WORD_UNSIGNED=4, NO_TRUNC=5). It generates byte strobes and lane-shifted write data, splits word-crossing accesses into two bus beats, and returns loads fully assembled and sign- or zero-extended. It is the writer/requester counterpart of the load-truncation path: the pipeline stalls on `req_ready` low.

## Interface
- `MISALIGNED_EN`, default 1: 1 = split word-crossing accesses into two beats; 0 = reject them with `misaligned_fault`.
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: memory-stage request present. Held stable until accepted.
- `req_ready` output 1: high iff FSM in IDLE. Combinational from state.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 3: truncation encoding. Values 6–7 are treated as WORD.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data in low bytes.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 32: extended load result. Valid when `done` and the request was a load; holds otherwise.
- `misaligned_fault` output 1: pulses with `done` when a crossing access is rejected.
- `bus_valid` output 1: beat request.
- `bus_ready` input 1: beat accepted when `bus_valid && bus_ready`.
- `bus_we` output 1: write beat.
- `bus_addr` output 32: word-aligned address (bits [1:0] = 0).
- `bus_wstrb` output 4: byte lanes written. Zero on reads.
- `bus_wdata` output 32: lane-aligned data.
- `bus_rvalid` input 1: read data return. At most one outstanding read; arrives ≥1 cycle after acceptance.
- `bus_rdata` input 32: returned word.

## Operation
- **Byte count `n`:** 1 for sizes 0 and 3; 2 for sizes 1 and 4; 4 otherwise.
- **Offset and crossing:** `o` = `addr[1:0]`. The access is a crossing access iff `o + n > 4`.
- **Acceptance:** on `req_valid && req_ready`, latch write, size, addr and wdata. Compute beat-0 fields and move to REQ0. If the access is crossing and `MISALIGNED_EN` = 0, go instead to FAULT.
- **Beat 0:**
  - `bus_addr = addr & ~3`
  - `bus_wstrb = ((1<<n)-1) << o`, truncated to 4 bits
  - `bus_wdata = wdata << 8*o`
- **Beat 1** (crossing only):
  - `bus_addr = (addr & ~3) + 4`, modulo 2^32, so 0xFFFFFFFx wraps to 0x00000000
  - `bus_wstrb = ((1<<n)-1) >> (4-o)`
  - `bus_wdata = wdata >> 8*(4-o)`
- **States:**
  - IDLE → REQ0 on accept.
  - REQ0: `bus_valid` = 1. On handshake:
    - write, not crossing → IDLE with `done`
    - write, crossing → REQ1
    - read → RSP0
  - RSP0: on `bus_rvalid`, capture `bus_rdata >> 8*o` into the assembly register, then → REQ1 if crossing, else → IDLE with `done`.
  - REQ1: `bus_valid` = 1. On handshake: write → IDLE with `done`; read → RSP1.
  - RSP1: on `bus_rvalid`, merge `bus_rdata` bytes into assembly bytes `4-o` and above, then → IDLE with `done`.
  - FAULT: one cycle, no bus activity → IDLE with `done` = `misaligned_fault` = 1. `rdata` is unchanged.
- **Load extension:**
  - Size 0: sign-extend bit 7. Size 3: zero-extend from 8 bits.
  - Size 1: sign-extend bit 15. Size 4: zero-extend from 16 bits.
  - Sizes 2 and 5–7: full 32 bits.
- **Bus stability:** `bus_addr`, `bus_we`, `bus_wstrb` and `bus_wdata` are registered. They must not change while `bus_valid` is high and `bus_ready` is low.
- **Ignored input:** `bus_rvalid` outside RSP0/RSP1 is ignored.

## Timing
- **Reset values:**
  - state IDLE, so `req_ready` = 1 during and after reset
  - `bus_valid`, `bus_we`, `done`, `misaligned_fault` = 0
  - `bus_addr`, `bus_wstrb`, `bus_wdata`, `rdata` = 0
- **Reset mid-operation:** the transaction is abandoned. `bus_valid` drops asynchronously and no `done` is produced.
- **`done` timing:** `done` is registered. It is high in the first cycle back in IDLE, and a new request may be accepted in that same cycle.
- **Latency** (accept cycle = 0, `bus_ready` = 1 always):
  - aligned store: `done` at cycle 2
  - crossing store: `done` at cycle 3
  - aligned load with `bus_rvalid` one cycle after acceptance: `done` at cycle 3
  - crossing load: `done` at cycle 5
  - fault: `done` at cycle 2
- **Bus stall:** each cycle of `bus_ready` low, or of `bus_rvalid` delay, adds one cycle.
- **Request changes:** `req_*` inputs are sampled only at acceptance. Changes afterwards have no effect.

## Test plan
- **Aligned byte store:** SW-byte to 0x1003, wdata 0x000000AB → one beat: addr 0x1000, wstrb 0b1000, wdata 0xAB000000; `done` at cycle 2.
- **Signed half load:** half load from 0x2002, bus returns 0x80FF1234 → `rdata` 0xFFFF80FF. Same access with size 4 → `rdata` 0x000080FF.
- **Crossing word store:** word store to 0x3003, wdata 0x11223344 → beat 0: 0x3000, wstrb 0b1000, wdata 0x44000000; beat 1: 0x3004, wstrb 0b0111, wdata 0x00112233.
- **Crossing word load with wrap:** load from 0xFFFFFFFE, returns 0xAABB0000 then 0x0000CCDD → second beat addr 0x00000000, `rdata` 0xCCDDAABB.
- **Backpressure and reset:** hold `bus_ready` low for 3 cycles in REQ0 → bus fields stable and `req_ready` low throughout. Then assert `reset_n` low mid-wait → `bus_valid` drops immediately, no `done`, `req_ready` = 1.
- **Fault and back-to-back:** with `MISALIGNED_EN` = 0, load from 0x0001 size 2 → `done` and `misaligned_fault` at cycle 2, no `bus_valid`. A second aligned request accepted in the `done` cycle completes normally.
